// File: rtl/mdu_ctrl_pkg.sv
// Op codes, FSM states and op-class decode helpers for the multiply/divide sequencer.
// MDU_MACC_EN (see mdu_ctrl.sv) enables the MADD/MSUB family decoded here.
package mdu_ctrl_pkg;

   localparam int MD_ITER = 32;
   localparam int CNT_W   = $clog2(MD_ITER);

   typedef enum logic [3:0] {
      MD_OP_MULT  = 4'd0,
      MD_OP_MULTU = 4'd1,
      MD_OP_DIV   = 4'd2,
      MD_OP_DIVU  = 4'd3,
      MD_OP_MTHI  = 4'd4,
      MD_OP_MTLO  = 4'd5,
      MD_OP_MADD  = 4'd6,
      MD_OP_MADDU = 4'd7,
      MD_OP_MSUB  = 4'd8,
      MD_OP_MSUBU = 4'd9
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PREP = 2'd1,
      ST_CALC = 2'd2,
      ST_FIX  = 2'd3
   } md_state_e;

   function automatic logic is_muldiv(input logic [3:0] op);
      return op inside {MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU};
   endfunction

   function automatic logic is_macc(input logic [3:0] op);
      return op inside {MD_OP_MADD, MD_OP_MADDU, MD_OP_MSUB, MD_OP_MSUBU};
   endfunction

   function automatic logic is_msub(input logic [3:0] op);
      return op inside {MD_OP_MSUB, MD_OP_MSUBU};
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return op inside {MD_OP_DIV, MD_OP_DIVU};
   endfunction

   function automatic logic is_signed(input logic [3:0] op);
      return op inside {MD_OP_MULT, MD_OP_DIV, MD_OP_MADD, MD_OP_MSUB};
   endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage issue/result bundle between the pipeline (master) and the multiply/divide sequencer (slave).
interface mdu_ctrl_if;
   logic        start;
   logic [3:0]  md_op;
   logic [31:0] opnd_a;
   logic [31:0] opnd_b;
   logic        flush;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, md_op, opnd_a, opnd_b, flush,
                   input  busy, done, div_by_zero, hi, lo);
   modport slave  (input  start, md_op, opnd_a, opnd_b, flush,
                   output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mdu_ctrl_step.sv
// One iteration of the sequencer loop: shift-add multiply on {acc_hi, multiplier},
// or restoring shift-subtract divide on {remainder, dividend/quotient}.
module mdu_step (
   input  logic        mul_i,
   input  logic [63:0] acc_i,
   input  logic [31:0] opnd_i,
   output logic [63:0] acc_o
);
   logic [32:0] sum;
   logic [32:0] shl;
   logic [31:0] diff;
   logic        ge;

   // Remainder stays below the divisor, so the restored value always fits in 32 bits.
   always_comb begin
      sum  = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
      shl  = {acc_i[63:32], acc_i[31]};
      ge   = (shl >= {1'b0, opnd_i});
      diff = shl[31:0] - opnd_i;
      if (mul_i) acc_o = {sum, acc_i[31:1]};
      else       acc_o = {(ge ? diff : shl[31:0]), acc_i[30:0], ge};
   end
endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide sequencer owning HI/LO; stalls EX while an op is in flight.
// Define MDU_MACC_EN to accept MADD/MADDU/MSUB/MSUBU (accumulate into {hi,lo}).
//
// state | meaning
// IDLE  | accepts start; MTHI/MTLO complete here
// PREP  | take magnitudes, record result signs, load counter
// CALC  | one product/quotient bit per cycle
// FIX   | sign fix-up, write HI/LO, pulse done
module mdu_ctrl
   import mdu_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   mdu_ctrl_if.slave  md
);
   md_state_e        state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [31:0]      a_q, a_d, b_q, b_d, m_q, m_d;
   logic [63:0]      acc_q, acc_d, step_acc;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
   logic             dbz_q, dbz_d, done_q, done_d, dbzp_q, dbzp_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic             long_op, sgn;
   logic [31:0]      abs_a, abs_b, quo, rem;
   logic [63:0]      prod;

`ifdef MDU_MACC_EN
   assign long_op = is_muldiv(md.md_op) | is_macc(md.md_op);
`else
   assign long_op = is_muldiv(md.md_op);
`endif

   mdu_step u_step (
      .mul_i  (~is_div(op_q)),
      .acc_i  (acc_q),
      .opnd_i (m_q),
      .acc_o  (step_acc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         m_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         done_q    <= 1'b0;
         dbzp_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         m_q       <= m_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dbz_q     <= dbz_d;
         done_q    <= done_d;
         dbzp_q    <= dbzp_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      m_d       = m_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = dbz_q;
      done_d    = 1'b0;
      dbzp_d    = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;

      sgn   = is_signed(op_q);
      abs_a = (sgn && a_q[31]) ? -a_q : a_q;
      abs_b = (sgn && b_q[31]) ? -b_q : b_q;
      prod  = neg_res_q ? -acc_q : acc_q;
      quo   = neg_res_q ? -acc_q[31:0] : acc_q[31:0];
      rem   = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];

      if (md.flush) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (md.start) begin
                  if (md.md_op == MD_OP_MTHI) hi_d = md.opnd_a;
                  else if (md.md_op == MD_OP_MTLO) lo_d = md.opnd_a;
                  else if (long_op) begin
                     op_d = md.md_op;
                     a_d  = md.opnd_a;
                     b_d  = md.opnd_b;
                     if (is_div(md.md_op) && md.opnd_b == '0) begin
                        dbz_d   = 1'b1;
                        state_d = ST_FIX;
                     end else begin
                        dbz_d   = 1'b0;
                        state_d = ST_PREP;
                     end
                  end
               end
            end
            ST_PREP: begin
               neg_res_d = sgn & (a_q[31] ^ b_q[31]);
               neg_rem_d = sgn & a_q[31];
               m_d       = is_div(op_q) ? abs_b : abs_a;
               acc_d     = {32'd0, (is_div(op_q) ? abs_a : abs_b)};
               cnt_d     = CNT_W'(MD_ITER - 1);
               state_d   = ST_CALC;
            end
            ST_CALC: begin
               acc_d = step_acc;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) state_d = ST_FIX;
            end
            ST_FIX: begin
               done_d  = 1'b1;
               dbzp_d  = dbz_q;
               state_d = ST_IDLE;
               if (!dbz_q) begin
                  if (is_div(op_q)) {hi_d, lo_d} = {rem, quo};
`ifdef MDU_MACC_EN
                  else if (is_msub(op_q)) {hi_d, lo_d} = {hi_q, lo_q} - prod;
                  else if (is_macc(op_q)) {hi_d, lo_d} = {hi_q, lo_q} + prod;
`endif
                  else {hi_d, lo_d} = prod;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign md.busy        = (state_q != ST_IDLE) | (md.start & long_op & ~md.flush);
   assign md.done        = done_q;
   assign md.div_by_zero = dbzp_q;
   assign md.hi          = hi_q;
   assign md.lo          = lo_q;

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Iterative multiply/divide sequencer for the EX stage of the pipelined MIPS core. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, runs a 32-iteration shift-add or restoring-divide loop, owns the architectural HI/LO registers and stalls the pipeline while an operation is in flight. It sits beside the single-cycle ALU, shares its rs/rt operand buses and is driven by the same decode stage.

## Interface
- MD_ITER, 32, iterations per multiply/divide (one result bit per cycle)
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  issue strobe from EX, valid for one cycle per instruction
- md_op  in  4  operation code (MD_OP_* encodings)
- opnd_a  in  32  rs value (multiplicand / dividend / MTHI-MTLO source)
- opnd_b  in  32  rt value (multiplier / divisor)
- flush  in  1  abort in-flight op (exception in MEM/WB)
- busy  out  1  stall request to hazard unit
- done  out  1  one-cycle completion pulse
- div_by_zero  out  1  one-cycle pulse, coincident with done
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- States: IDLE, PREP, CALC, FIX.
- IDLE + start + MTHI/MTLO: hi/lo written from opnd_a at that edge; no busy, no done.
- IDLE + start + MULT/MULTU/DIV/DIVU: latch operands, -> PREP. PREP: signed ops take absolute values, record result signs; iteration counter loaded with MD_ITER-1. -> CALC.
- CALC: one iteration per cycle; multiply = shift-add into 64-bit accumulator, divide = restoring shift-subtract (33-bit partial remainder). Counter reaches 0 -> FIX.
- FIX: negate product/quotient/remainder as required, write {hi,lo}, pulse done, -> IDLE.
- Multiply: {hi,lo} = full 64-bit product (signed: operands sign-extended).
- Divide: lo = quotient truncated toward zero, hi = remainder with sign of dividend. 0x80000000 / 0xFFFFFFFF (DIV) -> lo=0x80000000, hi=0.
- DIV/DIVU with opnd_b=0: IDLE -> FIX directly; hi/lo unchanged; done and div_by_zero pulse.
- start while state != IDLE: ignored.
- Unknown md_op: ignored, no busy.
- flush: any state -> IDLE at next edge; hi/lo unchanged; no done. flush and start in the same cycle: flush wins, start ignored.
- Reset mid-operation: immediately IDLE, hi=lo=0, all outputs 0.

## Timing
- Reset values: busy=0, done=0, div_by_zero=0, hi=0, lo=0, state IDLE.
- busy is combinational: (state != IDLE) | (start & long op & ~flush), so EX stalls in the issue cycle.
- Start sampled at edge E0; PREP cycle E0-E1; CALC E1-E33 (32 cycles); FIX E33-E34; hi/lo updated and done registered high at E34, for exactly one cycle. busy falls at E34. Total latency 34 cycles; pipeline may issue a new op in the cycle done is high.
- Divide-by-zero: done at E1, busy high for issue cycle plus one.
- hi/lo reads in the done cycle return the new values.

## Configuration
- MDU_MACC_EN defined: MADD/MADDU/MSUB/MSUBU accepted; same 34-cycle sequence, FIX writes {hi,lo} = {hi,lo} +/- product (64-bit, wraps modulo 2^64).
- Not defined: those encodings are treated as unknown (ignored, no busy, no done); accumulate adder/subtractor not synthesised.

## Structure
- const.vh: MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU, MD_OP_MTHI, MD_OP_MTLO, MD_OP_MADD, MD_OP_MADDU, MD_OP_MSUB, MD_OP_MSUBU, state encodings, MD_ITER default.
- Sub-module mdu_step: combinational single iteration (shift-add or shift-subtract-restore) on accumulator/remainder; mdu_ctrl holds FSM, counter, sign fix-up and HI/LO.

## Test plan
- MULT 0xFFFFFFFF x 0x00000002 -> done at E34, hi=0xFFFFFFFF, lo=0xFFFFFFFE; busy high issue cycle through E34; MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678 then DIVU 5/0 -> hi=0x12345678 unchanged, done and div_by_zero pulse at E1, busy 2 cycles.
- MULT 3x4, flush at 10th cycle after start -> IDLE next edge, no done, hi/lo unchanged; new start next cycle accepted normally; flush with start same cycle -> no busy after that cycle.
- rst_n low at 20th cycle of DIV -> hi=lo=0, busy=0 immediately; second start during busy ignored (result from first op only).
- MDU_MACC_EN: MTHI 0, MTLO 5, MADD 3x4 -> lo=0x11, hi=0; MSUBU 1x0x12 -> {hi,lo}=0xFFFFFFFF_FFFFFFFF; without macro MADD -> no busy, hi/lo unchanged.
